// File: rtl/vid_tim_meas.sv
// ============================================================================
//  Module      : vid_tim_meas
//  Description : Measures hsync width, line length, active pixels per line and
//                active lines per frame of a pixel-rate video timing stream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vid_tim_meas #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          daten,
    output logic [CW-1:0] Thsync_m,
    output logic [CW-1:0] Thlen_m,
    output logic [CW-1:0] Tactpix_m,
    output logic [CW-1:0] Tactlin_m,
    output logic          meas_vld,
    output logic          locked,
    output logic          err_line
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [CW-1:0] c_one     = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic          r_h_d, r_v_d, r_d_d;
    logic [CW-1:0] r_lcnt, r_hcnt, r_pcnt;
    logic          r_hseen, r_first, r_ferr;
    logic [CW-1:0] r_sh_hsw, r_sh_len, r_sh_pix, r_lin_cnt;
    logic [CW-1:0] r_thsync, r_thlen, r_tactpix, r_tactlin;
    logic          r_meas_vld, r_locked, r_err_line;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == c_cnt_max) ? v : v + c_one;
    endfunction

    logic          w_h_rise, w_h_fall, w_v_rise;
    logic [CW-1:0] w_lcnt_inc, w_len, w_pix_fin;
    logic          w_len_vld, w_len_err, w_pix_cap, w_lsat_now, w_same;
    logic [CW-1:0] w_sh_hsw_nxt, w_sh_len_nxt, w_sh_pix_nxt, w_lin_nxt;
    logic          w_ferr_nxt, w_first_nxt;

    assign w_h_rise   = hsync & ~r_h_d;
    assign w_h_fall   = ~hsync & r_h_d;
    assign w_v_rise   = vsync & ~r_v_d;

    assign w_lcnt_inc = sat_inc(r_lcnt);
    assign w_len      = w_lcnt_inc;
    assign w_len_vld  = w_h_rise & r_hseen;
    assign w_len_err  = w_len_vld & ~r_first & (w_len != r_sh_len);
    assign w_lsat_now = ~w_h_rise & (r_lcnt != c_cnt_max) & (w_lcnt_inc == c_cnt_max);

    // Pixel count runs one sample behind daten; the pending sample is folded in at line end.
    assign w_pix_fin  = r_d_d ? sat_inc(r_pcnt) : r_pcnt;
    assign w_pix_cap  = w_h_rise & (w_pix_fin != '0);

    // Line-end results as they will stand after this cycle; a coincident vsync publishes these.
    assign w_sh_hsw_nxt = w_h_fall  ? r_hcnt            : r_sh_hsw;
    assign w_sh_len_nxt = w_len_vld ? w_len             : r_sh_len;
    assign w_sh_pix_nxt = w_pix_cap ? w_pix_fin         : r_sh_pix;
    assign w_lin_nxt    = w_pix_cap ? sat_inc(r_lin_cnt) : r_lin_cnt;
    assign w_ferr_nxt   = r_ferr | w_len_err;
    assign w_first_nxt  = w_len_vld ? 1'b0 : r_first;

    assign w_same = (w_sh_hsw_nxt == r_thsync) && (w_sh_len_nxt == r_thlen) &&
                    (w_sh_pix_nxt == r_tactpix) && (w_lin_nxt == r_tactlin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_h_d      <= 1'b0;
            r_v_d      <= 1'b0;
            r_d_d      <= 1'b0;
            r_lcnt     <= '0;
            r_hcnt     <= '0;
            r_pcnt     <= '0;
            r_hseen    <= 1'b0;
            r_first    <= 1'b1;
            r_ferr     <= 1'b0;
            r_sh_hsw   <= '0;
            r_sh_len   <= '0;
            r_sh_pix   <= '0;
            r_lin_cnt  <= '0;
            r_thsync   <= '0;
            r_thlen    <= '0;
            r_tactpix  <= '0;
            r_tactlin  <= '0;
            r_meas_vld <= 1'b0;
            r_locked   <= 1'b0;
            r_err_line <= 1'b0;
        end else if (!ena) begin
            r_meas_vld <= 1'b0;
            r_err_line <= 1'b0;
        end else begin
            r_h_d      <= hsync;
            r_v_d      <= vsync;
            r_d_d      <= daten;
            r_meas_vld <= 1'b0;
            r_err_line <= w_len_err;

            r_lcnt <= w_h_rise ? '0 : w_lcnt_inc;
            if (w_h_rise) begin
                r_hseen <= 1'b1;
            end

            if (w_h_rise) begin
                r_hcnt <= c_one;
            end else if (hsync) begin
                r_hcnt <= sat_inc(r_hcnt);
            end

            r_pcnt <= w_h_rise ? '0 : w_pix_fin;

            r_sh_hsw  <= w_sh_hsw_nxt;
            r_sh_len  <= w_sh_len_nxt;
            r_sh_pix  <= w_sh_pix_nxt;
            r_lin_cnt <= w_lin_nxt;
            r_ferr    <= w_ferr_nxt;
            r_first   <= w_first_nxt;

            if (w_v_rise) begin
                r_lin_cnt <= '0;
                r_ferr    <= 1'b0;
                r_first   <= 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        r_sh_hsw <= '0;
                        r_sh_len <= '0;
                        r_sh_pix <= '0;
                        r_state  <= ST_MEAS;
                    end
                    default: begin
                        r_thsync   <= w_sh_hsw_nxt;
                        r_thlen    <= w_sh_len_nxt;
                        r_tactpix  <= w_sh_pix_nxt;
                        r_tactlin  <= w_lin_nxt;
                        r_meas_vld <= 1'b1;
                        r_locked   <= (r_state == ST_RUN) && w_same && !w_ferr_nxt;
                        r_state    <= ST_RUN;
                    end
                endcase
            end

            // Loss of hsync: drop back and restart measurement from scratch.
            if (w_lsat_now) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
                r_hseen  <= 1'b0;
                r_first  <= 1'b1;
            end
        end
    end

    assign Thsync_m  = r_thsync;
    assign Thlen_m   = r_thlen;
    assign Tactpix_m = r_tactpix;
    assign Tactlin_m = r_tactlin;
    assign meas_vld  = r_meas_vld;
    assign locked    = r_locked;
    assign err_line  = r_err_line;

endmodule

`default_nettype wire

// File: tb/tb_vid_tim_meas.sv
// ============================================================================
//  Module      : tb_vid_tim_meas
//  Description : Directed self-checking bench for vid_tim_meas (frames of
//                2 blank + 12 active lines, line 200, hsync 16, 160 pixels).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vid_tim_meas;

    localparam int CW = 12;

    logic          clk, rst_n, ena, hsync, vsync, daten;
    logic [CW-1:0] Thsync_m, Thlen_m, Tactpix_m, Tactlin_m;
    logic          meas_vld, locked, err_line;

    int checks   = 0;
    int failures = 0;
    int mv_cnt   = 0;
    int err_cnt  = 0;

    vid_tim_meas #(.CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .hsync     (hsync),
        .vsync     (vsync),
        .daten     (daten),
        .Thsync_m  (Thsync_m),
        .Thlen_m   (Thlen_m),
        .Tactpix_m (Tactpix_m),
        .Tactlin_m (Tactlin_m),
        .meas_vld  (meas_vld),
        .locked    (locked),
        .err_line  (err_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (meas_vld === 1'b1) mv_cnt++;
            if (err_line === 1'b1) err_cnt++;
        end
    end

    task automatic cyc(input logic h, input logic v, input logic d, input logic e);
        hsync = h; vsync = v; daten = d; ena = e;
        @(posedge clk);
        #1;
    endtask

    // Line 0 carries vsync (rising together with hsync); lines 2.. are active.
    task automatic drive_frame(input int l0len, input int nlines, input bit gap);
        for (int ln = 0; ln < nlines; ln++) begin
            int   len;
            logic hh, vv, dd;
            len = (ln == 0) ? l0len : 200;
            for (int c = 0; c < len; c++) begin
                hh = (c < 16);
                vv = (ln == 0);
                dd = (ln >= 2) && (c >= 20) && (c < 180);
                if (gap && ln == 5 && c == 100) repeat (50) cyc(hh, vv, dd, 1'b0);
                cyc(hh, vv, dd, 1'b1);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b0; hsync = 1'b0; vsync = 1'b0; daten = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Thsync_m !== 12'd0)  begin failures++; $display("FAIL reset_thsync got %0d want 0", Thsync_m); end
        checks++; if (Thlen_m !== 12'd0)   begin failures++; $display("FAIL reset_thlen got %0d want 0", Thlen_m); end
        checks++; if (Tactpix_m !== 12'd0) begin failures++; $display("FAIL reset_tactpix got %0d want 0", Tactpix_m); end
        checks++; if (Tactlin_m !== 12'd0) begin failures++; $display("FAIL reset_tactlin got %0d want 0", Tactlin_m); end
        checks++; if ({meas_vld, locked, err_line} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got %b want 000", {meas_vld, locked, err_line});
        end
        @(negedge clk); rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_basic_lock;
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 0) begin failures++; $display("FAIL basic_first_vrise mv got %0d want 0", mv_cnt); end
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 1) begin failures++; $display("FAIL basic_second_vrise mv got %0d want 1", mv_cnt); end
        checks++; if ({Thsync_m, Thlen_m, Tactpix_m} !== {12'd16, 12'd200, 12'd160}) begin
            failures++; $display("FAIL basic_values got %0d/%0d/%0d want 16/200/160", Thsync_m, Thlen_m, Tactpix_m);
        end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL basic_unlocked got %b want 0", locked); end
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 2) begin failures++; $display("FAIL basic_third_vrise mv got %0d want 2", mv_cnt); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL basic_locked got %b want 1", locked); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL basic_no_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_coincident_edges;
        drive_frame(200, 14, 1'b0);
        checks++; if (Tactlin_m !== 12'd12) begin failures++; $display("FAIL coincident_tactlin got %0d want 12", Tactlin_m); end
        checks++; if (mv_cnt !== 3) begin failures++; $display("FAIL coincident_mv got %0d want 3", mv_cnt); end
    endtask

    task automatic test_line_error;
        drive_frame(201, 14, 1'b0);
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL lerr_pulses got %0d want 1", err_cnt); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lerr_prev_locked got %b want 1", locked); end
        drive_frame(200, 14, 1'b0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lerr_unlock got %b want 0", locked); end
        checks++; if (Thlen_m !== 12'd200) begin failures++; $display("FAIL lerr_thlen got %0d want 200", Thlen_m); end
        drive_frame(200, 14, 1'b0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lerr_relock got %b want 1", locked); end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL lerr_no_more got %0d want 1", err_cnt); end
    endtask

    task automatic test_ena_gap;
        drive_frame(200, 14, 1'b1);
        drive_frame(200, 14, 1'b0);
        checks++; if ({Thsync_m, Thlen_m, Tactpix_m, Tactlin_m} !== {12'd16, 12'd200, 12'd160, 12'd12}) begin
            failures++; $display("FAIL gap_values got %0d/%0d/%0d/%0d want 16/200/160/12", Thsync_m, Thlen_m, Tactpix_m, Tactlin_m);
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_locked got %b want 1", locked); end
        checks++; if (mv_cnt !== 8) begin failures++; $display("FAIL gap_mv got %0d want 8", mv_cnt); end
    endtask

    task automatic test_hsync_loss;
        repeat (4200) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked got %b want 0", locked); end
        checks++; if ({Thsync_m, Thlen_m, Tactpix_m, Tactlin_m} !== {12'd16, 12'd200, 12'd160, 12'd12}) begin
            failures++; $display("FAIL loss_hold got %0d/%0d/%0d/%0d want 16/200/160/12", Thsync_m, Thlen_m, Tactpix_m, Tactlin_m);
        end
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 8) begin failures++; $display("FAIL loss_idle_vrise mv got %0d want 8", mv_cnt); end
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 9) begin failures++; $display("FAIL loss_remeas mv got %0d want 9", mv_cnt); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_meas_unlocked got %b want 0", locked); end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL loss_no_err got %0d want 1", err_cnt); end
    endtask

    task automatic test_async_reset;
        drive_frame(200, 7, 1'b0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL areset_pre_locked got %b want 1", locked); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({Thsync_m, Thlen_m, Tactpix_m, Tactlin_m} !== 48'd0) begin
            failures++; $display("FAIL areset_outputs got %0d/%0d/%0d/%0d want 0/0/0/0", Thsync_m, Thlen_m, Tactpix_m, Tactlin_m);
        end
        checks++; if ({meas_vld, locked, err_line} !== 3'b000) begin
            failures++; $display("FAIL areset_flags got %b want 000", {meas_vld, locked, err_line});
        end
        hsync = 1'b0; vsync = 1'b0; daten = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 10) begin failures++; $display("FAIL areset_first_vrise mv got %0d want 10", mv_cnt); end
        drive_frame(200, 14, 1'b0);
        checks++; if (mv_cnt !== 11) begin failures++; $display("FAIL areset_second_vrise mv got %0d want 11", mv_cnt); end
        checks++; if ({Thsync_m, Thlen_m, Tactpix_m, Tactlin_m} !== {12'd16, 12'd200, 12'd160, 12'd12}) begin
            failures++; $display("FAIL areset_values got %0d/%0d/%0d/%0d want 16/200/160/12", Thsync_m, Thlen_m, Tactpix_m, Tactlin_m);
        end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL areset_unlocked got %b want 0", locked); end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_coincident_edges();
        test_line_error();
        test_ena_gap();
        test_hsync_loss();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
